calc_dispatch_ctrl: RTL

- Sits between the top-level UI FSM and Calculator_Core, and owns a small table of matrix slot descriptors (valid, m, n) for the fixed-size regions of Matrix_Storage.
- Accepts one operation request at a time and validates operands: slot occupancy, opcode, and dimension compatibility.
- Drives the core's start and operand interface and holds it stable until the core reports done or the timeout expires.
- Updates the destination descriptor and returns a status response.

---
 rtl/calc_pkg.sv | 39 +++
 rtl/slot_desc_table.sv | 90 +++++++++
 rtl/calc_dispatch_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared op/status codes, dispatcher state encoding and slot sizing defaults
// for the calculator dispatch controller.
package calc_pkg;

    localparam int unsigned MAX_DIM_DEF    = 5;
    localparam int unsigned SLOT_WORDS_DEF = 25;

    localparam logic [2:0] OP_TRANS  = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_SCALAR = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;

    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_EMPTY_SRC    = 3'd1;
    localparam logic [2:0] ST_DIM_MISMATCH = 3'd2;
    localparam logic [2:0] ST_BAD_OP       = 3'd3;
    localparam logic [2:0] ST_TIMEOUT      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_START,
        S_WAIT,
        S_FINISH
    } state_e;

    function automatic logic [7:0] slot_base(input logic [1:0] slot,
                                             input int unsigned words);
        logic [31:0] prod;
        prod = 32'(slot) * words;
        return prod[7:0];
    endfunction

    // Only add and multiply read a second matrix operand.
    function automatic logic uses_src2(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/slot_desc_table.sv
// Matrix slot descriptor register file: host write/clear with range check and
// lock mask, plus a dispatcher update port that overrides host writes.
module slot_desc_table
    import calc_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SLOT_W    = 2,
    parameter int unsigned MAX_DIM   = MAX_DIM_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_we,
    input  logic                        i_clr,
    input  logic [SLOT_W-1:0]           i_slot,
    input  logic [31:0]                 i_m,
    input  logic [31:0]                 i_n,
    input  logic [NUM_SLOTS-1:0]        i_lock,
    input  logic                        i_upd_we,
    input  logic [SLOT_W-1:0]           i_upd_slot,
    input  logic                        i_upd_valid,
    input  logic [31:0]                 i_upd_m,
    input  logic [31:0]                 i_upd_n,
    output logic                        o_desc_err,
    output logic [NUM_SLOTS-1:0]        o_slot_valid,
    output logic [NUM_SLOTS-1:0]        o_valid_nxt,
    output logic [NUM_SLOTS-1:0][31:0]  o_m_nxt,
    output logic [NUM_SLOTS-1:0][31:0]  o_n_nxt
);

    logic [NUM_SLOTS-1:0]       valid_q, valid_d;
    logic [NUM_SLOTS-1:0][31:0] m_q, m_d;
    logic [NUM_SLOTS-1:0][31:0] n_q, n_d;
    logic                       err_q, err_d;
    logic                       in_range;

    always_comb begin
        valid_d  = valid_q;
        m_d      = m_q;
        n_d      = n_q;
        err_d    = 1'b0;
        in_range = (i_m >= 32'd1) && (i_m <= 32'(MAX_DIM)) &&
                   (i_n >= 32'd1) && (i_n <= 32'(MAX_DIM));

        if (i_clr) begin
            if (i_lock[i_slot]) begin
                err_d = 1'b1;
            end else begin
                valid_d[i_slot] = 1'b0;
                m_d[i_slot]     = '0;
                n_d[i_slot]     = '0;
            end
        end else if (i_we) begin
            if (i_lock[i_slot] || !in_range) begin
                err_d = 1'b1;
            end else begin
                valid_d[i_slot] = 1'b1;
                m_d[i_slot]     = i_m;
                n_d[i_slot]     = i_n;
            end
        end

        // Applied last so the dispatcher result wins any same-slot collision.
        if (i_upd_we) begin
            valid_d[i_upd_slot] = i_upd_valid;
            m_d[i_upd_slot]     = i_upd_m;
            n_d[i_upd_slot]     = i_upd_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            m_q     <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            m_q     <= m_d;
            n_q     <= n_d;
            err_q   <= err_d;
        end
    end

    assign o_desc_err   = err_q;
    assign o_slot_valid = valid_q;
    assign o_valid_nxt  = valid_d;
    assign o_m_nxt      = m_d;
    assign o_n_nxt      = n_d;

endmodule

// File: rtl/calc_dispatch_ctrl.sv
// Dispatcher between the UI FSM and Calculator_Core: validates one request,
// drives the core until done or timeout, updates the result descriptor.
module calc_dispatch_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned SLOT_WORDS  = SLOT_WORDS_DEF,
    parameter int unsigned MAX_DIM     = MAX_DIM_DEF,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_desc_we,
    input  logic [1:0]           i_desc_slot,
    input  logic [31:0]          i_desc_m,
    input  logic [31:0]          i_desc_n,
    input  logic                 i_desc_clr,
    output logic                 o_desc_err,
    output logic [NUM_SLOTS-1:0] o_slot_valid,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [2:0]           i_req_op,
    input  logic [1:0]           i_req_src1,
    input  logic [1:0]           i_req_src2,
    input  logic [31:0]          i_req_scalar,
    input  logic [1:0]           i_req_dst,
    output logic                 o_rsp_valid,
    output logic [2:0]           o_rsp_status,
    output logic [31:0]          o_rsp_m,
    output logic [31:0]          o_rsp_n,
    output logic                 o_busy,
    output logic                 o_start_calc,
    output logic [2:0]           o_op_code,
    output logic [7:0]           o_op1_addr,
    output logic [7:0]           o_op2_addr,
    output logic [7:0]           o_res_addr,
    output logic [31:0]          o_op1_m,
    output logic [31:0]          o_op1_n,
    output logic [31:0]          o_op2_m,
    output logic [31:0]          o_op2_n,
    input  logic                 i_calc_done
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       status_q, status_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
    logic [31:0]      scalar_q, scalar_d;
    logic             v1_q, v1_d, v2_q, v2_d;
    logic [31:0]      m1_q, m1_d, n1_q, n1_d, m2_q, m2_d, n2_q, n2_d;

    logic [NUM_SLOTS-1:0]       lock;
    logic                       upd_we, upd_valid;
    logic [31:0]                upd_m, upd_n;
    logic [NUM_SLOTS-1:0]       valid_nxt;
    logic [NUM_SLOTS-1:0][31:0] m_nxt, n_nxt;
    logic [31:0]                res_m, res_n;
    logic                       busy, has_op2;

    slot_desc_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (2),
        .MAX_DIM   (MAX_DIM)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_we         (i_desc_we),
        .i_clr        (i_desc_clr),
        .i_slot       (i_desc_slot),
        .i_m          (i_desc_m),
        .i_n          (i_desc_n),
        .i_lock       (lock),
        .i_upd_we     (upd_we),
        .i_upd_slot   (dst_q),
        .i_upd_valid  (upd_valid),
        .i_upd_m      (upd_m),
        .i_upd_n      (upd_n),
        .o_desc_err   (o_desc_err),
        .o_slot_valid (o_slot_valid),
        .o_valid_nxt  (valid_nxt),
        .o_m_nxt      (m_nxt),
        .o_n_nxt      (n_nxt)
    );

    always_comb begin
        res_m = m1_q;
        res_n = n1_q;
        if (op_q == OP_TRANS) begin
            res_m = n1_q;
            res_n = m1_q;
        end else if (op_q == OP_MUL) begin
            res_n = n2_q;
        end
    end

    always_comb begin
        lock = '0;
        if (state_q != S_IDLE) begin
            lock[src1_q] = 1'b1;
            lock[dst_q]  = 1'b1;
            if (uses_src2(op_q)) lock[src2_q] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        status_d  = status_q;
        op_d      = op_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        dst_d     = dst_q;
        scalar_d  = scalar_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        m1_d      = m1_q;
        n1_d      = n1_q;
        m2_d      = m2_q;
        n2_d      = n2_q;
        upd_we    = 1'b0;
        upd_valid = 1'b0;
        upd_m     = '0;
        upd_n     = '0;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    // Snapshot from the table's next state so a same-cycle write is seen.
                    op_d     = i_req_op;
                    src1_d   = i_req_src1;
                    src2_d   = i_req_src2;
                    dst_d    = i_req_dst;
                    scalar_d = i_req_scalar;
                    v1_d     = valid_nxt[i_req_src1];
                    m1_d     = m_nxt[i_req_src1];
                    n1_d     = n_nxt[i_req_src1];
                    v2_d     = valid_nxt[i_req_src2];
                    m2_d     = m_nxt[i_req_src2];
                    n2_d     = n_nxt[i_req_src2];
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_FINISH;
                if (op_q > OP_MUL) begin
                    status_d = ST_BAD_OP;
                end else if (!v1_q || (uses_src2(op_q) && !v2_q)) begin
                    status_d = ST_EMPTY_SRC;
                end else if ((op_q == OP_ADD) && ((m1_q != m2_q) || (n1_q != n2_q))) begin
                    status_d = ST_DIM_MISMATCH;
                end else if ((op_q == OP_MUL) && (n1_q != m2_q)) begin
                    status_d = ST_DIM_MISMATCH;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_calc_done) begin
                    upd_we    = 1'b1;
                    upd_valid = 1'b1;
                    upd_m     = res_m;
                    upd_n     = res_n;
                    status_d  = ST_OK;
                    state_d   = S_FINISH;
                end else if (cnt_q == CNT_LAST) begin
                    upd_we   = 1'b1;
                    status_d = ST_TIMEOUT;
                    state_d  = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            status_q <= '0;
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            scalar_q <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            m1_q     <= '0;
            n1_q     <= '0;
            m2_q     <= '0;
            n2_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dst_q    <= dst_d;
            scalar_q <= scalar_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            m1_q     <= m1_d;
            n1_q     <= n1_d;
            m2_q     <= m2_d;
            n2_q     <= n2_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign has_op2      = (op_q != OP_TRANS) && (op_q != OP_SCALAR);
    assign o_req_ready  = !busy;
    assign o_busy       = busy;
    assign o_start_calc = (state_q == S_START);
    assign o_rsp_valid  = (state_q == S_FINISH);
    assign o_rsp_status = o_rsp_valid ? status_q : '0;
    assign o_rsp_m      = (o_rsp_valid && status_q == ST_OK) ? res_m : '0;
    assign o_rsp_n      = (o_rsp_valid && status_q == ST_OK) ? res_n : '0;

    // Core interface comes purely from the request snapshot, so it stays fixed
    // even when the result overwrites a source slot in place.
    assign o_op_code  = busy ? op_q : '0;
    assign o_op1_addr = busy ? slot_base(src1_q, SLOT_WORDS) : '0;
    assign o_op2_addr = (busy && has_op2) ? slot_base(src2_q, SLOT_WORDS) : '0;
    assign o_res_addr = busy ? slot_base(dst_q, SLOT_WORDS) : '0;
    assign o_op1_m    = busy ? m1_q : '0;
    assign o_op1_n    = busy ? n1_q : '0;
    assign o_op2_m    = !busy              ? '0       :
                        (op_q == OP_SCALAR) ? scalar_q :
                        (op_q == OP_TRANS)  ? '0       : m2_q;
    assign o_op2_n    = (busy && has_op2) ? n2_q : '0;

endmodule
